// File: rtl/usb_tx_sched_if.sv
// usb_tx_sched_if: IN-token bus between the device controller, endpoint sources and the TX scheduler.
interface usb_tx_sched_if;
    logic        usb_busreset;
    logic [3:0]  endpt_sel;
    logic        usb_txact;
    logic        usb_txpop;
    logic        usb_txpktfin;
    logic [7:0]  ep0_dat;
    logic [11:0] ep0_len;
    logic        ep0_send;
    logic [7:0]  ep2_dat;
    logic [11:0] ep2_len;
    logic        ep2_cork;
    logic [6:0]  uart_state;
    logic [7:0]  usb_txdat;
    logic [11:0] usb_txdat_len;
    logic        usb_txcork;
    logic        usb_txval;
    logic        notif_pending;
    logic        notif_sent;

    modport master (
        output usb_busreset, endpt_sel, usb_txact, usb_txpop, usb_txpktfin,
               ep0_dat, ep0_len, ep0_send, ep2_dat, ep2_len, ep2_cork, uart_state,
        input  usb_txdat, usb_txdat_len, usb_txcork, usb_txval, notif_pending, notif_sent
    );

    modport slave (
        input  usb_busreset, endpt_sel, usb_txact, usb_txpop, usb_txpktfin,
               ep0_dat, ep0_len, ep0_send, ep2_dat, ep2_len, ep2_cork, uart_state,
        output usb_txdat, usb_txdat_len, usb_txcork, usb_txval, notif_pending, notif_sent
    );
endinterface

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: muxes EP0/EP2 TX sources and generates the CDC SERIAL_STATE notification on the interrupt endpoint.
module usb_tx_sched #(
    parameter logic [3:0]  CTRL_EP  = 4'd0,
    parameter logic [3:0]  NOTIF_EP = 4'd1,
    parameter logic [3:0]  DATA_EP  = 4'd2,
    parameter logic [15:0] IF_NUM   = 16'd0
) (
    input logic           PHY_CLKOUT,
    input logic           RESET,
    usb_tx_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_FIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [6:0]  snap_q, snap_d;
    logic [6:0]  last_q, last_d;
    logic        notif_sent_q, notif_sent_d;
    logic        txact_q;
    logic        notif_sel, txact_rise, pending;
    logic [6:0]  pkt_state;
    logic [79:0] pkt;
    logic [6:0]  bit_off;
    logic [7:0]  notif_byte;

    assign notif_sel  = bus.endpt_sel == NOTIF_EP;
    assign txact_rise = bus.usb_txact && !txact_q;
    assign pending    = (bus.uart_state != last_q) || (state_q != IDLE);

    // Before the snapshot is taken the packet previews the live UART state.
    assign pkt_state  = (state_q == IDLE) ? bus.uart_state : snap_q;
    assign pkt        = {8'h00, 1'b0, pkt_state, 8'h00, 8'h02, IF_NUM[15:8], IF_NUM[7:0],
                         8'h00, 8'h00, 8'h20, 8'hA1};
    assign bit_off    = {idx_q, 3'b000};
    assign notif_byte = (idx_q < 4'd10) ? pkt[bit_off +: 8] : 8'h00;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        last_d       = last_q;
        notif_sent_d = 1'b0;
        if (bus.usb_busreset) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            snap_d  = 7'd0;
            last_d  = 7'd0;
        end else begin
            case (state_q)
                IDLE: if (txact_rise && notif_sel && pending) begin
                    state_d = SEND;
                    snap_d  = bus.uart_state;
                    idx_d   = 4'd0;
                end
                SEND: if (!bus.usb_txact) begin
                    state_d = IDLE;
                end else if (bus.usb_txpop && notif_sel) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = (idx_q == 4'd9) ? WAIT_FIN : SEND;
                end
                WAIT_FIN: if (bus.usb_txpktfin) begin
                    state_d      = IDLE;
                    last_d       = snap_q;
                    notif_sent_d = 1'b1;
                end else if (!bus.usb_txact) begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge PHY_CLKOUT or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            snap_q       <= 7'd0;
            last_q       <= 7'd0;
            notif_sent_q <= 1'b0;
            txact_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            last_q       <= last_d;
            notif_sent_q <= notif_sent_d;
            txact_q      <= bus.usb_txact;
        end
    end

    always_comb begin
        bus.usb_txdat     = 8'h00;
        bus.usb_txdat_len = 12'd0;
        bus.usb_txcork    = 1'b1;
        bus.usb_txval     = 1'b0;
        if (bus.endpt_sel == CTRL_EP) begin
            bus.usb_txdat     = bus.ep0_dat;
            bus.usb_txdat_len = bus.ep0_len;
            bus.usb_txcork    = 1'b0;
            bus.usb_txval     = bus.ep0_send;
        end else if (bus.endpt_sel == DATA_EP) begin
            bus.usb_txdat     = bus.ep2_dat;
            bus.usb_txdat_len = bus.ep2_len;
            bus.usb_txcork    = bus.ep2_cork;
        end else if (notif_sel && pending) begin
            bus.usb_txdat     = notif_byte;
            bus.usb_txdat_len = 12'd10;
            bus.usb_txcork    = 1'b0;
        end
    end

    assign bus.notif_pending = pending;
    assign bus.notif_sent    = notif_sent_q;
endmodule
